// File: rtl/nibbler_pkg.sv
// Shared types and constants for the nibble processor fetch/sequencer slice.
package nibbler_pkg;

  localparam int PC_W        = 12;
  localparam int INSTR_W     = 8;
  localparam int CTRL_ADDR_W = 7;
  localparam int OPC_W       = 4;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP0 = 2'd2,
    STEP1 = 2'd3
  } seq_state_t;

  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;

  // Control ROM address: opcode, inverted carry, inverted zero, phase.
  function automatic logic [CTRL_ADDR_W-1:0] make_ctrl_addr(
    input logic [OPC_W-1:0] opc,
    input logic             c,
    input logic             z,
    input logic             ph
  );
    return {opc, ~c, ~z, ph};
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: load beats increment, wraps silently at the top of the
// address space, and only moves while the sequencer enables it.
module pc_counter
  import nibbler_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            load_n,
  input  logic            inc_n,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC: load has priority over increment; hold otherwise.
  always_comb begin
    pc_d = pc_q;
    if (en) begin
      if (!load_n) begin
        pc_d = load_val;
      end else if (!inc_n) begin
        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and two-phase sequencer for the nibble processor.
// Holds PC, IR, phase toggle and C/Z flags; builds the control ROM address.
// Optional single-step support is compiled in with NIBBLER_STEP_EN.
//
//   state | meaning
//   HALT  | frozen at an instruction boundary, strobes ignored, halted=1
//   RUN   | free-running; leaves only after a phase-1 cycle with run=0
//   STEP0 | single-step fetch cycle (NIBBLER_STEP_EN only)
//   STEP1 | single-step execute cycle (NIBBLER_STEP_EN only)
module fetch_sequencer
  import nibbler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INSTR_W-1:0]     instr_in,
  input  logic                   pc_inc_n,
  input  logic                   pc_load_n,
  input  logic                   flags_load_n,
  input  logic                   carry_in,
  input  logic                   zero_in,
  input  logic                   run,
  input  logic                   step,
  output logic [PC_W-1:0]        prog_addr,
  output logic [CTRL_ADDR_W-1:0] ctrl_addr,
  output logic [OPC_W-1:0]       operand,
  output logic                   halted
);

  seq_state_t         state_q, state_d;
  logic               halted_q, halted_d;
  logic               phase_q, phase_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               c_q, c_d;
  logic               z_q, z_d;
  logic               active;
  logic [PC_W-1:0]    jump_target;
  logic               step_unused;

  // Without the step option the pulse has no effect.
  assign step_unused = step;

  // Every non-HALT state is an executing cycle.
  assign active = (state_q != HALT);

  // Jump target: high nibble from the operand, low byte is the second
  // instruction byte now sitting at prog_addr.
  assign jump_target = {ir_q[OPC_W-1:0], instr_in};

  pc_counter u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (active),
    .load_n   (pc_load_n),
    .inc_n    (pc_inc_n),
    .load_val (jump_target),
    .pc       (prog_addr)
  );

  // Next state; halts are only taken after a phase-1 cycle so instructions
  // are never split.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: begin
        if (run) begin
          state_d = RUN;
        end
`ifdef NIBBLER_STEP_EN
        else if (step) begin
          state_d = STEP0;
        end
`endif
      end
      RUN: begin
        if ((phase_q == PH_EXEC) && !run) begin
          state_d = HALT;
        end
      end
`ifdef NIBBLER_STEP_EN
      STEP0: state_d = STEP1;
      STEP1: state_d = run ? RUN : HALT;
`endif
      default: state_d = HALT;
    endcase
    halted_d = (state_d == HALT);
  end

  // Datapath next values: IR loads in fetch, flags on strobe, phase toggles.
  always_comb begin
    ir_d    = ir_q;
    phase_d = phase_q;
    c_d     = c_q;
    z_d     = z_q;
    if (active) begin
      phase_d = ~phase_q;
      if (phase_q == PH_FETCH) begin
        ir_d = instr_in;
      end
      if (!flags_load_n) begin
        c_d = carry_in;
        z_d = zero_in;
      end
    end
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HALT;
      halted_q <= 1'b1;
      phase_q  <= PH_FETCH;
      ir_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      phase_q  <= phase_d;
      ir_q     <= ir_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end

  assign ctrl_addr = make_ctrl_addr(ir_q[INSTR_W-1:OPC_W], c_q, z_q, phase_q);
  assign operand   = ir_q[OPC_W-1:0];
  assign halted    = halted_q;

endmodule
